// File: rtl/multi_pattern_detector_pkg.sv
// Shared helpers and reset defaults for the multi-lane serial pattern detector.
package multi_pattern_detector_pkg;

   localparam int unsigned MAX_PAT_LEN = 16;
   localparam int unsigned DEF_LEN     = 0;
   localparam logic        DEF_OVERLAP = 1'b1;

   typedef enum logic {
      MODE_NON_OVERLAP = 1'b0,
      MODE_OVERLAP     = 1'b1
   } overlap_mode_e;

   // Mask with the low len bits set; callers zero-extend their operands to MAX_PAT_LEN.
   function automatic logic [MAX_PAT_LEN-1:0] len_mask(input int unsigned len);
      logic [MAX_PAT_LEN-1:0] mask;
      mask = '0;
      for (int unsigned b = 0; b < MAX_PAT_LEN; b++) begin
         mask[b] = (b < len);
      end
      return mask;
   endfunction

   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/multi_pattern_detector_lane.sv
// One detector lane: programmable pattern/length/overlap, fill tracking,
// registered match pulse and saturating match counter.
module pat_match_lane
   import multi_pattern_detector_pkg::*;
#(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8,
   parameter int LEN_W   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PAT_LEN-1:0] hist_next,
   input  logic               in_valid,
   input  logic               cfg_we,
   input  logic [PAT_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               hit,
   output logic               match,
   output logic [CNT_W-1:0]   count
);

   localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [PAT_LEN-1:0]     pattern_reg;
   logic [LEN_W-1:0]       len_reg;
   overlap_mode_e          overlap_reg;
   logic [LEN_W-1:0]       fill_reg;
   logic [LEN_W-1:0]       fill_next;
   logic [LEN_W-1:0]       len_load;
   logic [CNT_W-1:0]       count_reg;
   logic                   match_reg;
   logic [MAX_PAT_LEN-1:0] hist_ext;
   logic [MAX_PAT_LEN-1:0] pattern_ext;
   logic [MAX_PAT_LEN-1:0] mask;

   assign len_load = LEN_W'(clamp_len(32'(cfg_len), PAT_LEN));

   // Evaluation always uses the currently held config, even on a config-write edge.
   always_comb begin
      fill_next   = (fill_reg < FILL_MAX) ? fill_reg + 1'b1 : fill_reg;
      hist_ext    = '0;
      hist_ext[PAT_LEN-1:0] = hist_next;
      pattern_ext = '0;
      pattern_ext[PAT_LEN-1:0] = pattern_reg;
      mask        = len_mask(32'(len_reg));
      hit         = in_valid && (len_reg != '0) && (fill_next >= len_reg) &&
                    (((hist_ext ^ pattern_ext) & mask) == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pattern_reg <= '0;
         len_reg     <= LEN_W'(DEF_LEN);
         overlap_reg <= overlap_mode_e'(DEF_OVERLAP);
         fill_reg    <= '0;
         count_reg   <= '0;
         match_reg   <= 1'b0;
      end else begin
         match_reg <= hit;
         if (cfg_we) begin
            pattern_reg <= cfg_pattern;
            len_reg     <= len_load;
            overlap_reg <= overlap_mode_e'(cfg_overlap);
            fill_reg    <= '0;
         end else if (in_valid) begin
            fill_reg <= (hit && overlap_reg == MODE_NON_OVERLAP) ? '0 : fill_next;
         end
         if (cnt_clr) begin
            count_reg <= '0;
         end else if (hit && count_reg != CNT_MAX) begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

   assign match = match_reg;
   assign count = count_reg;

endmodule

// File: rtl/multi_pattern_detector.sv
// Runtime-programmable serial detector: shared history register feeding
// NUM_PAT independent pattern lanes.
module multi_pattern_detector
   import multi_pattern_detector_pkg::*;
#(
   parameter  int NUM_PAT = 2,
   parameter  int PAT_LEN = 4,
   parameter  int CNT_W   = 8,
   parameter  int LEN_W   = $clog2(PAT_LEN + 1),
   localparam int IDX_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic                     in_bit,
   input  logic                     cfg_we,
   input  logic [IDX_W-1:0]         cfg_idx,
   input  logic [PAT_LEN-1:0]       cfg_pattern,
   input  logic [LEN_W-1:0]         cfg_len,
   input  logic                     cfg_overlap,
   input  logic                     cnt_clr,
   output logic                     match,
   output logic [NUM_PAT-1:0]       match_vec,
   output logic [NUM_PAT*CNT_W-1:0] match_cnt
);

   logic [PAT_LEN-1:0] hist_reg;
   logic [PAT_LEN-1:0] hist_next;
   logic [NUM_PAT-1:0] lane_we;
   logic [NUM_PAT-1:0] lane_hit;
   logic               match_reg;

   always_comb begin
      hist_next = in_valid ? {hist_reg[PAT_LEN-2:0], in_bit} : hist_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_reg  <= '0;
         match_reg <= 1'b0;
      end else begin
         hist_reg  <= hist_next;
         match_reg <= |lane_hit;
      end
   end

   // Out-of-range indices decode to no lane at all.
   generate
      for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_lane
         assign lane_we[gi] = cfg_we && (cfg_idx == IDX_W'(gi));

         pat_match_lane #(
            .PAT_LEN (PAT_LEN),
            .CNT_W   (CNT_W),
            .LEN_W   (LEN_W)
         ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .hist_next   (hist_next),
            .in_valid    (in_valid),
            .cfg_we      (lane_we[gi]),
            .cfg_pattern (cfg_pattern),
            .cfg_len     (cfg_len),
            .cfg_overlap (cfg_overlap),
            .cnt_clr     (cnt_clr),
            .hit         (lane_hit[gi]),
            .match       (match_vec[gi]),
            .count       (match_cnt[gi*CNT_W +: CNT_W])
         );
      end
   endgenerate

   assign match = match_reg;

endmodule

// File: tb/tb_multi_pattern_detector.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against a stream-history reference model.
module tb_multi_pattern_detector;

   localparam int NP = 3;
   localparam int PL = 4;
   localparam int CW = 8;
   localparam int LW = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid, in_bit, cfg_we, cfg_overlap, cnt_clr;
   logic [1:0]     cfg_idx;
   logic [PL-1:0]  cfg_pattern;
   logic [LW-1:0]  cfg_len;
   logic           match;
   logic [NP-1:0]  match_vec;
   logic [NP*CW-1:0] match_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: raw accepted-bit stream plus per-lane settings.
   bit   q[$];
   int   m_pat[NP], m_len[NP], m_fill[NP], m_cnt[NP];
   bit   m_ov[NP];
   logic [NP-1:0] exp_vec;
   logic          exp_match;

   always #5 clk = ~clk;

   multi_pattern_detector #(
      .NUM_PAT (NP),
      .PAT_LEN (PL),
      .CNT_W   (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .cfg_we      (cfg_we),
      .cfg_idx     (cfg_idx),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cnt_clr     (cnt_clr),
      .match       (match),
      .match_vec   (match_vec),
      .match_cnt   (match_cnt)
   );

   function automatic bit tail_matches(int lane);
      for (int k = 0; k < m_len[lane]; k++) begin
         if (q.size() <= k) return 1'b0;
         if (q[q.size()-1-k] != m_pat[lane][k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < NP; i++) begin
         m_pat[i] = 0; m_len[i] = 0; m_ov[i] = 1'b1; m_fill[i] = 0; m_cnt[i] = 0;
      end
      exp_vec   = '0;
      exp_match = 1'b0;
   endtask

   // Drives one clock of stimulus and advances the model; no comparisons here.
   task automatic cycle(input bit v, input bit b, input bit we, input int idx,
                        input int pat, input int len, input bit ov, input bit clr);
      int fn;
      bit h;
      logic [NP-1:0] nv;
      in_valid = v; in_bit = b; cfg_we = we; cfg_idx = idx[1:0];
      cfg_pattern = pat[PL-1:0]; cfg_len = len[LW-1:0]; cfg_overlap = ov; cnt_clr = clr;
      nv = '0;
      if (v) begin
         q.push_back(b);
         if (q.size() > 32) void'(q.pop_front());
      end
      for (int i = 0; i < NP; i++) begin
         h = 1'b0;
         if (v) begin
            fn = (m_fill[i] < PL) ? m_fill[i] + 1 : PL;
            h = (m_len[i] != 0) && (fn >= m_len[i]) && tail_matches(i);
            m_fill[i] = (h && !m_ov[i]) ? 0 : fn;
         end
         nv[i] = h;
         if (clr) m_cnt[i] = 0;
         else if (h && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
      end
      if (we && idx < NP) begin
         m_pat[idx]  = pat & ((1 << PL) - 1);
         m_len[idx]  = (len > PL) ? PL : len;
         m_ov[idx]   = ov;
         m_fill[idx] = 0;
      end
      @(posedge clk);
      #1;
      exp_vec   = nv;
      exp_match = |nv;
      cfg_we = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0;
      $display("[%0t] valid=%0b bit=%0b we=%0b idx=%0d pat=%h len=%0d ov=%0b clr=%0b exp_vec=%b",
               $time, v, b, we, idx, pat, len, ov, clr, nv);
   endtask

   task automatic cfg(input int idx, input int pat, input int len, input bit ov);
      cycle(1'b0, 1'b0, 1'b1, idx, pat, len, ov, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 0; in_bit = 0; cfg_we = 0; cfg_idx = 0; cfg_pattern = 0;
      cfg_len = 0; cfg_overlap = 0; cnt_clr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (match !== 1'b0 || match_vec !== '0) begin
         errors++;
         $display("FAIL reset_outputs: match=%b vec=%b, expected 0/000", match, match_vec);
      end
      checks++;
      if (match_cnt !== '0) begin
         errors++;
         $display("FAIL reset_counts: cnt=%h, expected 0", match_cnt);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      bit bits[6] = '{0, 1, 1, 0, 1, 0};
      logic [NP-1:0] want[6] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b010};
      cfg(0, 4'b0011, 3, 1'b1);
      cfg(1, 4'b1010, 4, 1'b1);
      for (int k = 0; k < 6; k++) begin
         cycle(1'b1, bits[k], 1'b0, 0, 0, 0, 1'b0, 1'b0);
         checks++;
         if (match_vec !== exp_vec || match !== exp_match) begin
            errors++;
            $display("FAIL basic_model bit%0d: vec=%b match=%b, expected %b/%b", k, match_vec, match, exp_vec, exp_match);
         end
         checks++;
         if (match_vec !== want[k]) begin
            errors++;
            $display("FAIL basic_table bit%0d: vec=%b, expected %b", k, match_vec, want[k]);
         end
      end
      checks++;
      if (match_cnt[0 +: CW] !== 8'd1 || match_cnt[CW +: CW] !== 8'd1) begin
         errors++;
         $display("FAIL basic_counts: lane0=%0d lane1=%0d, expected 1/1", match_cnt[0 +: CW], match_cnt[CW +: CW]);
      end
   endtask

   task automatic test_overlap();
      bit bits[6] = '{1, 0, 1, 0, 1, 0};
      bit want_ov[6] = '{0, 0, 0, 1, 0, 1};
      bit want_no[6] = '{0, 0, 0, 1, 0, 0};
      cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
      cfg(1, 4'b1010, 4, 1'b1);
      for (int k = 0; k < 6; k++) begin
         cycle(1'b1, bits[k], 1'b0, 0, 0, 0, 1'b0, 1'b0);
         checks++;
         if (match_vec !== exp_vec || match_vec[1] !== want_ov[k]) begin
            errors++;
            $display("FAIL overlap_on bit%0d: vec=%b, expected %b (lane1=%b)", k, match_vec, exp_vec, want_ov[k]);
         end
      end
      checks++;
      if (match_cnt[CW +: CW] !== 8'd2) begin
         errors++;
         $display("FAIL overlap_on_count: lane1=%0d, expected 2", match_cnt[CW +: CW]);
      end
      cfg(1, 4'b1010, 4, 1'b0);
      for (int k = 0; k < 6; k++) begin
         cycle(1'b1, bits[k], 1'b0, 0, 0, 0, 1'b0, 1'b0);
         checks++;
         if (match_vec !== exp_vec || match_vec[1] !== want_no[k]) begin
            errors++;
            $display("FAIL overlap_off bit%0d: vec=%b, expected %b (lane1=%b)", k, match_vec, exp_vec, want_no[k]);
         end
      end
      checks++;
      if (match_cnt[CW +: CW] !== 8'd3) begin
         errors++;
         $display("FAIL overlap_off_count: lane1=%0d, expected 3", match_cnt[CW +: CW]);
      end
   endtask

   task automatic test_gap();
      cfg(0, 4'b0011, 3, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
         checks++;
         if (match_vec !== 3'b000 || match !== 1'b0) begin
            errors++;
            $display("FAIL gap_idle%0d: vec=%b match=%b, expected 000/0", k, match_vec, match);
         end
      end
      cycle(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
      checks++;
      if (match_vec[0] !== 1'b1 || match_vec !== exp_vec || match !== 1'b1) begin
         errors++;
         $display("FAIL gap_final: vec=%b match=%b, expected lane0 set (%b)", match_vec, match, exp_vec);
      end
   endtask

   task automatic test_saturate();
      cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
      cfg(0, 4'b0001, 1, 1'b1);
      for (int k = 0; k < 300; k++) begin
         cycle(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
         checks++;
         if (match_vec !== exp_vec || match_cnt[0 +: CW] !== 8'(m_cnt[0])) begin
            errors++;
            $display("FAIL sat_step%0d: vec=%b cnt=%0d, expected %b/%0d", k, match_vec, match_cnt[0 +: CW], exp_vec, m_cnt[0]);
         end
      end
      checks++;
      if (match_cnt[0 +: CW] !== 8'd255) begin
         errors++;
         $display("FAIL sat_value: lane0=%0d, expected 255", match_cnt[0 +: CW]);
      end
      cycle(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
      checks++;
      if (match_cnt[0 +: CW] !== 8'd0 || match_vec[0] !== 1'b1) begin
         errors++;
         $display("FAIL sat_clr_priority: lane0=%0d vec=%b, expected 0 with lane0 pulse", match_cnt[0 +: CW], match_vec);
      end
   endtask

   task automatic test_cfg_same_edge();
      bit bits[3] = '{0, 1, 0};
      bit want[3] = '{0, 0, 1};
      cfg(0, 4'b0011, 3, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 0, 4'b0010, 2, 1'b1, 1'b0);
      checks++;
      if (match_vec[0] !== 1'b1 || match_vec !== exp_vec) begin
         errors++;
         $display("FAIL cfgedge_old_cfg: vec=%b, expected lane0 set (%b)", match_vec, exp_vec);
      end
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, bits[k], 1'b0, 0, 0, 0, 1'b0, 1'b0);
         checks++;
         if (match_vec[0] !== want[k] || match_vec !== exp_vec) begin
            errors++;
            $display("FAIL cfgedge_fresh bit%0d: vec=%b, expected lane0=%b (%b)", k, match_vec, want[k], exp_vec);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 500; k++) begin
         bit we;
         we = ($urandom_range(0, 9) == 0);
         cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), we,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
         checks++;
         if (match_vec !== exp_vec || match !== exp_match) begin
            errors++;
            $display("FAIL rand_match step%0d: vec=%b match=%b, expected %b/%b", k, match_vec, match, exp_vec, exp_match);
         end
         for (int i = 0; i < NP; i++) begin
            checks++;
            if (match_cnt[i*CW +: CW] !== 8'(m_cnt[i])) begin
               errors++;
               $display("FAIL rand_count step%0d lane%0d: cnt=%0d, expected %0d", k, i, match_cnt[i*CW +: CW], m_cnt[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      cfg(0, 4'b0011, 3, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
      cfg(1, 4'b0001, 1, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
      // lane1 (pattern "1") pulses now and has a nonzero count; reset must clear both at once
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (match !== 1'b0 || match_vec !== '0 || match_cnt !== '0) begin
         errors++;
         $display("FAIL midrst_async: match=%b vec=%b cnt=%h, expected all 0", match, match_vec, match_cnt);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 0, 0, 0, 1'b0, 1'b0);
         checks++;
         if (match_vec !== 3'b000 || match !== 1'b0 || match_vec !== exp_vec) begin
            errors++;
            $display("FAIL midrst_nomatch step%0d: vec=%b match=%b, expected 000/0", k, match_vec, match);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overlap();
      test_gap();
      test_saturate();
      test_cfg_same_edge();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
